tcam_access_ctrl: RTL
=====================

Name: tcam_access_ctrl

Overview:
Sequences all accesses to one tcam instance: table updates from the control plane and key lookups from the datapath. Lookups are pipelined and results are tagged in order. A write first drains in-flight lookups, then issues WE and waits out TCAM BUSY, so no lookup ever observes a half-written entry. A fairness counter bounds lookup starvation under write bursts.

Parameters:
C_TCAM_ADDR_WIDTH, 5, TCAM address width (32 entries)
C_TCAM_DATA_WIDTH, 16, key/mask width
C_LKP_LATENCY, 2, cycles from CMP_DIN driven to MATCH/MATCH_ADDR valid (>=1)
C_LKP_QUOTA, 4, lookups guaranteed between consecutive writes when lookups are pending
C_BUSY_TIMEOUT, 64, max cycles waiting for BUSY to fall after WE

Ports:
CLK  in  1  clock
RSTN  in  1  async active-low reset
WR_REQ  in  1  write request, held until WR_ACK
WR_ADDR  in  ADDR_W  entry address
WR_DATA  in  DATA_W  entry data
WR_MASK  in  DATA_W  entry mask
WR_ACK  out  1  one-cycle pulse: write complete
LKP_VALID  in  1  lookup request valid
LKP_READY  out  1  lookup accepted when VALID&READY
LKP_KEY  in  DATA_W  search key
LKP_MASK  in  DATA_W  search mask
RES_VALID  out  1  result valid, one cycle per accepted lookup
RES_HIT  out  1  match flag
RES_ADDR  out  ADDR_W  match address (0 when miss)
ERR  out  1  sticky: BUSY timeout
TCAM_WE  out  1  to tcam WE
TCAM_ADDR_WR  out  ADDR_W  to ADDR_WR
TCAM_DIN  out  DATA_W  to DIN
TCAM_DATA_MASK  out  DATA_W  to DATA_MASK
TCAM_BUSY  in  1  from tcam BUSY
TCAM_CMP_DIN  out  DATA_W  to CMP_DIN
TCAM_CMP_DATA_MASK  out  DATA_W  to CMP_DATA_MASK
TCAM_MATCH  in  1  from MATCH
TCAM_MATCH_ADDR  in  ADDR_W  from MATCH_ADDR

Behaviour:
- Reset (async, RSTN=0): FSM=IDLE, all outputs 0, in-flight shift register cleared, quota counter=C_LKP_QUOTA, ERR=0. Reset mid-write drops the write with no WR_ACK; requester re-requests.
- Lookup path: TCAM_CMP_DIN/MASK registered from LKP_KEY/MASK on accept, otherwise 0. A C_LKP_LATENCY-deep valid shift register tracks in-flight lookups. RES_VALID/HIT/ADDR are registered from the TCAM outputs when the tap is set. Total request-to-result latency = C_LKP_LATENCY+1. One lookup per cycle sustained. RES_ADDR=0 on miss. TCAM_MATCH without a tracked lookup is ignored.
- LKP_READY=1 only in IDLE and not (WR_REQ & quota==0).
- FSM:
  - IDLE: WR_REQ and (quota==0 or no LKP_VALID) -> DRAIN. Each accepted lookup while WR_REQ is pending decrements quota (saturating at 0).
  - DRAIN: LKP_READY=0; wait until shift register empty and TCAM_BUSY=0 -> WRITE.
  - WRITE: TCAM_WE=1 for exactly one cycle; ADDR/DIN/MASK driven from the WR_* inputs in the same cycle, 0 otherwise -> WAIT.
  - WAIT: minimum 2 cycles. Leaves when TCAM_BUSY=0 after that minimum: pulse WR_ACK, reload quota, -> IDLE. Leaves on timeout counter reaching C_BUSY_TIMEOUT: set ERR, pulse WR_ACK, -> IDLE.
- Simultaneous WR_REQ and LKP_VALID in IDLE with quota>0: lookup wins.
- Back-to-back writes: a write is never re-entered without returning to IDLE for at least 1 cycle.
- WR_* inputs must be stable while WR_REQ=1. WR_REQ dropped before WR_ACK is a protocol violation; the in-progress write still completes.

Test Plan:
- Write 0x1234@0x00, 0xabcd@0x0f, 0x5678@0x1e (mask 0); each gives exactly one TCAM_WE pulse and one WR_ACK. Then look up the same three keys back-to-back -> three RES_VALID, HIT=1, ADDR=0x00,0x0f,0x1e in order, latency 3.
- Lookup 0x9999 -> RES_VALID=1, HIT=0, ADDR=0.
- Continuous LKP_VALID with WR_REQ raised -> exactly 4 lookups accepted, then LKP_READY=0 and drain. TCAM_WE does not fire until the 4 results are returned. Lookups resume after WR_ACK.
- Hold TCAM_BUSY=1 for 100 cycles after WE -> WR_ACK at timeout (64 cycles), ERR=1 and stays set.
- Assert RSTN=0 during WAIT -> outputs 0 immediately, no WR_ACK. After release, a re-issued write completes normally.

Source files
------------

// File: rtl/tcam_access_ctrl.sv
// Access sequencer for a single TCAM: pipelined in-order lookups plus
// drain-then-write table updates with a lookup fairness quota and BUSY timeout.
module tcam_access_ctrl #(
  parameter int C_TCAM_ADDR_WIDTH = 5,
  parameter int C_TCAM_DATA_WIDTH = 16,
  parameter int C_LKP_LATENCY     = 2,
  parameter int C_LKP_QUOTA       = 4,
  parameter int C_BUSY_TIMEOUT    = 64
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic                         WR_REQ,
  input  logic [C_TCAM_ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [C_TCAM_DATA_WIDTH-1:0] WR_DATA,
  input  logic [C_TCAM_DATA_WIDTH-1:0] WR_MASK,
  output logic                         WR_ACK,
  input  logic                         LKP_VALID,
  output logic                         LKP_READY,
  input  logic [C_TCAM_DATA_WIDTH-1:0] LKP_KEY,
  input  logic [C_TCAM_DATA_WIDTH-1:0] LKP_MASK,
  output logic                         RES_VALID,
  output logic                         RES_HIT,
  output logic [C_TCAM_ADDR_WIDTH-1:0] RES_ADDR,
  output logic                         ERR,
  output logic                         TCAM_WE,
  output logic [C_TCAM_ADDR_WIDTH-1:0] TCAM_ADDR_WR,
  output logic [C_TCAM_DATA_WIDTH-1:0] TCAM_DIN,
  output logic [C_TCAM_DATA_WIDTH-1:0] TCAM_DATA_MASK,
  input  logic                         TCAM_BUSY,
  output logic [C_TCAM_DATA_WIDTH-1:0] TCAM_CMP_DIN,
  output logic [C_TCAM_DATA_WIDTH-1:0] TCAM_CMP_DATA_MASK,
  input  logic                         TCAM_MATCH,
  input  logic [C_TCAM_ADDR_WIDTH-1:0] TCAM_MATCH_ADDR
);

  localparam int AW  = C_TCAM_ADDR_WIDTH;
  localparam int DW  = C_TCAM_DATA_WIDTH;
  localparam int LAT = C_LKP_LATENCY;
  localparam int QW  = $clog2(C_LKP_QUOTA + 1);
  localparam int TW  = $clog2(C_BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WRITE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             run_r;
  logic [QW-1:0]    quota_r;
  logic [TW-1:0]    wcnt_r;
  logic [LAT-1:0]   vld_r;
  logic             we_r;
  logic [AW-1:0]    wr_addr_r;
  logic [DW-1:0]    din_r;
  logic [DW-1:0]    dmask_r;
  logic             ack_r;
  logic             err_r;
  logic [DW-1:0]    cmp_din_r;
  logic [DW-1:0]    cmp_mask_r;
  logic             res_valid_r;
  logic             res_hit_r;
  logic [AW-1:0]    res_addr_r;

  logic             wr_pend_s;
  logic             quota_zero_s;
  logic             ready_s;
  logic             fire_s;
  logic             drained_s;
  logic             wait_done_s;
  logic             timeout_s;
  logic             we_s;
  logic             ack_s;
  logic             err_set_s;

  // The requester still holds WR_REQ in the cycle it sees WR_ACK; masking it
  // there keeps a completed write from being restarted.
  assign wr_pend_s    = WR_REQ & ~ack_r;
  assign quota_zero_s = (quota_r == {QW{1'b0}});
  assign ready_s      = run_r & (state_r == ST_IDLE) & ~(wr_pend_s & quota_zero_s);
  assign fire_s       = LKP_VALID & ready_s;
  assign drained_s    = (vld_r == {LAT{1'b0}}) & ~TCAM_BUSY;
  assign wait_done_s  = (wcnt_r != {TW{1'b0}}) & ~TCAM_BUSY;
  assign timeout_s    = (wcnt_r == TW'(C_BUSY_TIMEOUT - 1));

  // State register and post-reset run enable.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= ST_IDLE;
      run_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      run_r   <= 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run_r && wr_pend_s && (quota_zero_s || !LKP_VALID)) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drained_s) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_WRITE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (wait_done_s || timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode; the registered copies line up WE with the WRITE state.
  always_comb begin
    we_s      = (state_nxt_s == ST_WRITE);
    ack_s     = (state_r == ST_WAIT) && (state_nxt_s == ST_IDLE);
    err_set_s = (state_r == ST_WAIT) && !wait_done_s && timeout_s;
  end

  // Write-side and status output registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      we_r      <= 1'b0;
      wr_addr_r <= {AW{1'b0}};
      din_r     <= {DW{1'b0}};
      dmask_r   <= {DW{1'b0}};
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      we_r      <= we_s;
      wr_addr_r <= we_s ? WR_ADDR : {AW{1'b0}};
      din_r     <= we_s ? WR_DATA : {DW{1'b0}};
      dmask_r   <= we_s ? WR_MASK : {DW{1'b0}};
      ack_r     <= ack_s;
      err_r     <= err_r | err_set_s;
    end
  end

  // Lookup pipeline: compare inputs, in-flight tracker, result capture.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cmp_din_r   <= {DW{1'b0}};
      cmp_mask_r  <= {DW{1'b0}};
      vld_r       <= {LAT{1'b0}};
      res_valid_r <= 1'b0;
      res_hit_r   <= 1'b0;
      res_addr_r  <= {AW{1'b0}};
    end else begin
      cmp_din_r   <= fire_s ? LKP_KEY : {DW{1'b0}};
      cmp_mask_r  <= fire_s ? LKP_MASK : {DW{1'b0}};
      vld_r[0]    <= fire_s;
      for (int i = 1; i < LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
      end
      res_valid_r <= vld_r[LAT-1];
      res_hit_r   <= vld_r[LAT-1] & TCAM_MATCH;
      res_addr_r  <= (vld_r[LAT-1] && TCAM_MATCH) ? TCAM_MATCH_ADDR : {AW{1'b0}};
    end
  end

  // Fairness quota and BUSY wait counter.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      quota_r <= QW'(C_LKP_QUOTA);
      wcnt_r  <= {TW{1'b0}};
    end else begin
      if (ack_s) begin
        quota_r <= QW'(C_LKP_QUOTA);
      end else if (fire_s && wr_pend_s && !quota_zero_s) begin
        quota_r <= quota_r - QW'(1);
      end else begin
        quota_r <= quota_r;
      end
      wcnt_r <= (state_r == ST_WAIT) ? wcnt_r + TW'(1) : {TW{1'b0}};
    end
  end

  assign LKP_READY          = ready_s;
  assign WR_ACK             = ack_r;
  assign ERR                = err_r;
  assign TCAM_WE            = we_r;
  assign TCAM_ADDR_WR       = wr_addr_r;
  assign TCAM_DIN           = din_r;
  assign TCAM_DATA_MASK     = dmask_r;
  assign TCAM_CMP_DIN       = cmp_din_r;
  assign TCAM_CMP_DATA_MASK = cmp_mask_r;
  assign RES_VALID          = res_valid_r;
  assign RES_HIT            = res_hit_r;
  assign RES_ADDR           = res_addr_r;

endmodule
